vga_fb_fetch_arbiter: RTL and testbench

Feeds the VGA controller's red/green/blue pixel inputs from a single-port framebuffer memory shared with the SIMD core's result writer. It prefetches scan-out pixels into a small FIFO ahead of display and arbitrates each memory cycle between display reads and SIMD writes. Display reads are guaranteed priority whenever the FIFO runs low. It sits between the framebuffer RAM, the SIMD writeback port and VGAController.

---
 rtl/vga_fb_fetch_arbiter_if.sv | 26 ++
 rtl/vga_fb_fetch_arbiter.sv | 77 +++++++
 tb/tb_vga_fb_fetch_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vga_fb_fetch_arbiter_if.sv
// vga_fb_fetch_arbiter_if: pixel, SIMD write and framebuffer memory signals of the fetch arbiter
interface vga_fb_fetch_arbiter_if #(parameter int ADDR_W = 19);
  logic frame_sync;
  logic pix_pop;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic underflow;
  logic wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0] wr_data;
  logic wr_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rd;
  logic mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  modport master (
    output frame_sync, pix_pop, wr_req, wr_addr, wr_data, mem_rdata,
    input red, green, blue, underflow, wr_gnt, mem_addr, mem_rd, mem_we, mem_wdata
  );
  modport slave (
    input frame_sync, pix_pop, wr_req, wr_addr, wr_data, mem_rdata,
    output red, green, blue, underflow, wr_gnt, mem_addr, mem_rd, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_fetch_arbiter.sv
// vga_fb_fetch_arbiter: prefetches scan-out pixels into a FIFO and shares the framebuffer port with SIMD writes
module vga_fb_fetch_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W = 19,
  parameter int FIFO_DEPTH = 16,
  parameter int FILL_LEVEL = 8,
  parameter int MEM_LAT = 2
) (
  input logic clk,
  input logic reset,
  vga_fb_fetch_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 2;
  localparam logic [PW-1:0] FILL = PW'(FILL_LEVEL);
  localparam logic [PW-1:0] DEPTH = PW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  logic [23:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [MEM_LAT-1:0] tag;
  logic [ADDR_W-1:0] faddr;
  logic fen;
  logic [PW-1:0] pend;
  logic rd_lo, do_rd, do_wr, push, pop;
  // pend counts FIFO entries plus reads still in flight, so reads never overrun the FIFO
  always_comb begin
    pend = PW'(cnt);
    for (int i = 0; i < MEM_LAT; i++) pend = pend + PW'(tag[i]);
    rd_lo = fen && pend < FILL;
    do_rd = !reset && (rd_lo || (!bus.wr_req && fen && pend < DEPTH));
    do_wr = !reset && !rd_lo && bus.wr_req;
  end
  assign bus.mem_rd = do_rd;
  assign bus.mem_we = do_wr;
  assign bus.wr_gnt = do_wr;
  assign bus.mem_addr = do_rd ? faddr : do_wr ? bus.wr_addr : '0;
  assign bus.mem_wdata = do_wr ? bus.wr_data : '0;
  assign push = tag[MEM_LAT-1] && !bus.frame_sync;
  assign pop = bus.pix_pop && cnt != '0 && !bus.frame_sync;
  always_ff @(posedge clk)
    if (push) fifo[wp] <= bus.mem_rdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      tag <= '0;
      faddr <= '0;
      fen <= 1'b1;
      bus.red <= '0;
      bus.green <= '0;
      bus.blue <= '0;
      bus.underflow <= 1'b0;
    end else if (bus.frame_sync) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      tag <= '0;
      faddr <= '0;
      fen <= 1'b1;
    end else begin
      tag <= MEM_LAT'({tag, do_rd});
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (do_rd) begin
        faddr <= faddr + 1'b1;
        if (faddr == LAST) fen <= 1'b0;
      end
      if (bus.pix_pop) begin
        {bus.red, bus.green, bus.blue} <= pop ? fifo[rp] : 24'h0;
        if (!pop) bus.underflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_vga_fb_fetch_arbiter.sv
// tb_vga_fb_fetch_arbiter: randomized scoreboard bench against a queue-based model of the fetch arbiter
module tb_vga_fb_fetch_arbiter;
  localparam int H = 8, V = 4, AW = 6, DEPTH = 16, FILL = 8, LAT = 2, N = H * V;
  typedef struct { logic [23:0] d; int due; } infl_t;
  typedef struct { logic [23:0] rgb; logic uf; } pix_t;
  logic clk = 0, reset = 1, probe = 0;
  vga_fb_fetch_arbiter_if #(.ADDR_W(AW)) bus();
  vga_fb_fetch_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH),
    .FILL_LEVEL(FILL), .MEM_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [23:0] tb_mem [64];
  logic [23:0] rpipe [LAT];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 64; i++) tb_mem[i] <= 24'(i);
    else if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    rpipe[0] <= bus.mem_rd ? tb_mem[bus.mem_addr] : 24'($urandom);
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata = rpipe[LAT-1];
  logic [23:0] fq [$];
  infl_t infl [$];
  pix_t pix_q [$];
  logic [23:0] ref_mem [64];
  logic [23:0] cur_rgb;
  int faddr, cyc, tests, fails;
  bit fen, exp_uf, pix_chk, granted;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk or posedge probe) begin : mon
    int p;
    bit lo, erd, ewe, arr;
    logic [AW-1:0] ea;
    logic [23:0] ewd;
    pix_t pe;
    infl_t it;
    if (probe) begin
      check("reset_outputs", {bus.red, bus.green, bus.blue, bus.underflow, bus.wr_gnt,
        bus.mem_addr, bus.mem_rd, bus.mem_we, bus.mem_wdata}, 64'd0);
      fq.delete(); infl.delete(); pix_q.delete();
      faddr = 0; fen = 1; exp_uf = 0; pix_chk = 0; cur_rgb = 0; granted = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 24'(i);
    end else if (!reset) begin
      if (pix_chk) begin
        pe = pix_q.pop_front();
        cur_rgb = pe.rgb;
        exp_uf = pe.uf;
      end
      check("pixel", {bus.red, bus.green, bus.blue}, cur_rgb);
      check("underflow", bus.underflow, exp_uf);
      p = fq.size() + infl.size();
      lo = fen && p < FILL;
      erd = lo || (!bus.wr_req && fen && p < DEPTH);
      ewe = !lo && bus.wr_req;
      ea = erd ? AW'(faddr) : ewe ? bus.wr_addr : '0;
      ewd = ewe ? bus.wr_data : '0;
      check("mem_op", {bus.mem_rd, bus.mem_we, bus.wr_gnt, bus.mem_addr, bus.mem_wdata},
        {erd, ewe, ewe, ea, ewd});
      arr = infl.size() > 0 && infl[0].due == cyc;
      pix_chk = bus.pix_pop && !bus.frame_sync;
      if (pix_chk) begin
        pe.rgb = fq.size() > 0 ? fq[0] : 24'h0;
        pe.uf = exp_uf || fq.size() == 0;
        pix_q.push_back(pe);
      end
      if (ewe) ref_mem[bus.wr_addr] = bus.wr_data;
      if (bus.frame_sync) begin
        fq.delete(); infl.delete();
        faddr = 0; fen = 1;
      end else begin
        if (pix_chk && fq.size() > 0) void'(fq.pop_front());
        if (arr) begin
          it = infl.pop_front();
          fq.push_back(it.d);
        end
        if (erd) begin
          it.d = ref_mem[faddr];
          it.due = cyc + LAT;
          infl.push_back(it);
          if (faddr == N - 1) fen = 0;
          faddr++;
        end
      end
      granted = bus.wr_gnt;
    end
    if (!probe) cyc++;
  end
  task automatic step(input bit pop, input bit sync, input bit wrp);
    @(posedge clk);
    #1;
    bus.frame_sync = sync;
    bus.pix_pop = pop && !sync;
    if (!bus.wr_req || granted) begin
      bus.wr_req = wrp;
      bus.wr_addr = AW'($urandom);
      bus.wr_data = 24'($urandom);
    end
  endtask
  task automatic rand_step();
    step($urandom_range(9) < 7, $urandom_range(49) == 0, 1'($urandom_range(1)));
  endtask
  initial begin
    bus.frame_sync = 0; bus.pix_pop = 0; bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    #2 probe = 1;
    #1 probe = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (30) step(0, 0, 1);
    repeat (20) step(0, 0, 0);
    repeat (45) step(1, 0, 1'($urandom_range(1)));
    step(0, 1, 0);
    repeat (800) rand_step();
    @(posedge clk);
    #3 reset = 1;
    #1 probe = 1;
    #1 probe = 0;
    @(posedge clk);
    #1 reset = 0;
    repeat (300) rand_step();
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
